// File: rtl/int_addsub_wbq_pkg.sv
// int_addsub_wbq_pkg: shared widths, entry/register structs and reset constant for the writeback queue.
package int_addsub_wbq_pkg;
  localparam int RISCV_ARCH = 64;
  localparam int CFG_REG_TAG_WIDTH = 4;
  localparam int WBQ_PTR_W = 4;
  localparam int WBQ_CNT_W = 5;
  typedef struct packed {
    logic [5:0]                   waddr;
    logic [RISCV_ARCH-1:0]        wdata;
    logic [CFG_REG_TAG_WIDTH-1:0] wtag;
  } int_addsub_wbq_entry_type;
  typedef struct packed {
    logic                         inflight_v;
    logic [5:0]                   inflight_waddr;
    logic [CFG_REG_TAG_WIDTH-1:0] inflight_wtag;
    logic [WBQ_PTR_W-1:0]         wr_ptr;
    logic [WBQ_PTR_W-1:0]         rd_ptr;
    logic [WBQ_CNT_W-1:0]         count;
  } int_addsub_wbq_registers;
  localparam int_addsub_wbq_registers int_addsub_wbq_r_reset = '0;
endpackage

// File: rtl/int_addsub_wbq_mem.sv
// int_addsub_wbq_mem: entry storage with registered write and asynchronous read; data array is not reset.
module int_addsub_wbq_mem
  import int_addsub_wbq_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  int_addsub_wbq_entry_type i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output int_addsub_wbq_entry_type o_rdata
);
  int_addsub_wbq_entry_type mem_q [2**AW];
  always_ff @(posedge i_clk)
    if (i_we) mem_q[i_waddr] <= i_wdata;
  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/int_addsub_wbq.sv
// int_addsub_wbq: writeback queue behind IntAddSub; credit-based issue, in-order FIFO writeback.
// Optional INT_ADDSUB_WBQ_BYPASS_EN presents an arriving result directly when the FIFO is empty.
module int_addsub_wbq
  import int_addsub_wbq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_issue_valid,
  output logic                         o_issue_ready,
  input  logic [5:0]                   i_issue_waddr,
  input  logic [CFG_REG_TAG_WIDTH-1:0] i_issue_wtag,
  input  logic [RISCV_ARCH-1:0]        i_res,
  input  logic                         i_flush,
  output logic                         o_wb_valid,
  input  logic                         i_wb_ready,
  output logic [5:0]                   o_wb_waddr,
  output logic [RISCV_ARCH-1:0]        o_wb_wdata,
  output logic [CFG_REG_TAG_WIDTH-1:0] o_wb_wtag,
  output logic                         o_empty
);
  localparam logic [WBQ_CNT_W-1:0] DEPTH = WBQ_CNT_W'(1 << DEPTH_LOG2);
  localparam logic [WBQ_PTR_W-1:0] PMASK = WBQ_PTR_W'((1 << DEPTH_LOG2) - 1);
  int_addsub_wbq_registers r_q, r_d;
  int_addsub_wbq_entry_type in_e, rd_e, out_e;
  logic fire, arrive, head_v, byp, push, pop;
  int_addsub_wbq_mem #(.AW(DEPTH_LOG2)) u_mem (
    .i_clk  (i_clk),
    .i_we   (push),
    .i_waddr(r_q.wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata(in_e),
    .i_raddr(r_q.rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata(rd_e)
  );
  always_comb begin
    r_d = r_q;
    o_issue_ready = (r_q.count + WBQ_CNT_W'(r_q.inflight_v)) < DEPTH;
    fire = i_issue_valid & o_issue_ready & ~i_flush;
    arrive = r_q.inflight_v & (|r_q.inflight_waddr) & ~i_flush;
    head_v = |r_q.count;
    in_e = '{waddr: r_q.inflight_waddr, wdata: i_res, wtag: r_q.inflight_wtag};
`ifdef INT_ADDSUB_WBQ_BYPASS_EN
    byp = arrive & ~head_v;
`else
    byp = 1'b0;
`endif
    o_wb_valid = head_v | byp;
    // zero the data outputs when idle so stale array contents never leak out
    out_e = head_v ? rd_e : byp ? in_e : '0;
    o_wb_waddr = out_e.waddr;
    o_wb_wdata = out_e.wdata;
    o_wb_wtag = out_e.wtag;
    o_empty = ~head_v & ~r_q.inflight_v;
    pop = head_v & i_wb_ready;
    push = arrive & ~(byp & i_wb_ready);
    r_d.inflight_v = fire;
    r_d.inflight_waddr = fire ? i_issue_waddr : r_q.inflight_waddr;
    r_d.inflight_wtag = fire ? i_issue_wtag : r_q.inflight_wtag;
    r_d.wr_ptr = push ? (r_q.wr_ptr + 1'b1) & PMASK : r_q.wr_ptr;
    r_d.rd_ptr = pop ? (r_q.rd_ptr + 1'b1) & PMASK : r_q.rd_ptr;
    r_d.count = r_q.count + WBQ_CNT_W'(push) - WBQ_CNT_W'(pop);
    if (i_flush) r_d = int_addsub_wbq_r_reset;
  end
  always_ff @(posedge i_clk, negedge i_nrst)
    if (!i_nrst) r_q <= int_addsub_wbq_r_reset;
    else r_q <= r_d;
endmodule

// File: tb/tb_int_addsub_wbq.sv
// tb_int_addsub_wbq: directed plus randomized bench against a queue-based reference model.
module tb_int_addsub_wbq;
`ifdef INT_ADDSUB_WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [5:0]  a;
    logic [63:0] d;
    logic [3:0]  t;
  } ent_t;
  logic clk = 1'b0, nrst = 1'b0;
  logic iv = 1'b0, fl = 1'b0, rdy = 1'b0;
  logic [5:0] wa = '0;
  logic [3:0] tg = '0;
  logic [63:0] res = '0;
  logic ir, wv, emp;
  logic [5:0] wba;
  logic [63:0] wbd;
  logic [3:0] wbt;
  int checks = 0, failures = 0, fires = 0;
  ent_t q[$], popq[$];
  bit m_inf = 1'b0;
  logic [5:0] m_a = '0;
  logic [3:0] m_t = '0;
  always #5 clk = ~clk;
  int_addsub_wbq dut (
    .i_clk(clk), .i_nrst(nrst), .i_issue_valid(iv), .o_issue_ready(ir),
    .i_issue_waddr(wa), .i_issue_wtag(tg), .i_res(res), .i_flush(fl),
    .o_wb_valid(wv), .i_wb_ready(rdy), .o_wb_waddr(wba), .o_wb_wdata(wbd),
    .o_wb_wtag(wbt), .o_empty(emp)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [5:0] a, input logic [3:0] t,
                     input logic [63:0] r, input logic f, input logic rd);
    bit e_rdy, e_byp, e_v, consumed;
    ent_t e_out;
    iv = v; wa = a; tg = t; res = r; fl = f; rdy = rd;
    e_rdy = (q.size() + int'(m_inf)) < 4;
    e_byp = BYP && q.size() == 0 && m_inf && m_a != 0 && !f;
    e_v = q.size() != 0 || e_byp;
    e_out = q.size() != 0 ? q[0] : e_byp ? ent_t'{m_a, r, m_t} : '0;
    @(negedge clk);
    chk("issue_ready", ir, e_rdy);
    chk("wb_valid", wv, e_v);
    chk("wb_waddr", wba, e_out.a);
    chk("wb_wdata", wbd, e_out.d);
    chk("wb_wtag", wbt, e_out.t);
    chk("empty", emp, q.size() == 0 && !m_inf);
    if (v && ir && !f) fires++;
    if (wv && rd) popq.push_back(ent_t'{wba, wbd, wbt});
    @(posedge clk);
    consumed = 1'b0;
    if (f) begin
      q.delete();
      m_inf = 1'b0;
    end else begin
      if (e_v && rd) begin
        if (q.size() != 0) void'(q.pop_front());
        else consumed = 1'b1;
      end
      if (m_inf && m_a != 0 && !consumed) q.push_back(ent_t'{m_a, r, m_t});
      m_inf = v && e_rdy;
      if (m_inf) begin m_a = a; m_t = t; end
    end
    #1;
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, wv, 1'b0);
    chk({tag, "_waddr"}, wba, 6'd0);
    chk({tag, "_wdata"}, wbd, 64'd0);
    chk({tag, "_wtag"}, wbt, 4'd0);
    chk({tag, "_ready"}, ir, 1'b1);
    chk({tag, "_empty"}, emp, 1'b1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("rst");
    @(negedge clk) nrst = 1'b1;
    @(posedge clk) #1;
    // single op waddr=5 tag=3 data 0x11
    popq.delete();
    cyc(1, 6'd5, 4'd3, 64'h0, 0, 1);
    cyc(0, 6'd0, 4'd0, 64'h11, 0, 1);
    cyc(0, 6'd0, 4'd0, 64'h0, 0, 1);
    cyc(0, 6'd0, 4'd0, 64'h0, 0, 1);
    chk("t1_count", popq.size(), 1);
    chk("t1_entry", popq[0], ent_t'{6'd5, 64'h11, 4'd3});
    // x0 destination is dropped
    popq.delete();
    cyc(1, 6'd0, 4'd1, 64'h0, 0, 1);
    cyc(0, 6'd0, 4'd0, 64'h7, 0, 1);
    cyc(0, 6'd0, 4'd0, 64'h0, 0, 1);
    chk("t2_nowb", popq.size(), 0);
    // credit limit with writeback stalled, then in-order drain
    fires = 0;
    for (int k = 0; k < 7; k++) cyc(1, 6'(k + 1), 4'(k), 64'(k), 0, 0);
    chk("t3_accepted", fires, 4);
    popq.delete();
    for (int k = 0; k < 6; k++) cyc(0, 6'd0, 4'd0, 64'h0, 0, 1);
    chk("t3_drained", popq.size(), 4);
    for (int k = 0; k < 4 && k < popq.size(); k++) chk("t3_data", popq[k].d, 64'(k + 1));
    // steady stream with push and pop in the same cycle and wrapping pointers
    for (int k = 0; k < 14; k++) cyc(1, 6'(k + 10), 4'(k), 64'(k + 100), 0, k % 3 != 0);
    for (int k = 0; k < 6; k++) cyc(0, 6'd0, 4'd0, 64'(k + 114), 0, 1);
    // flush with two queued and one in flight
    cyc(1, 6'd7, 4'd1, 64'h0, 0, 0);
    cyc(1, 6'd8, 4'd2, 64'hA1, 0, 0);
    cyc(1, 6'd9, 4'd3, 64'hA2, 0, 0);
    popq.delete();
    cyc(1, 6'd10, 4'd4, 64'hDEAD, 1, 0);
    cyc(0, 6'd0, 4'd0, 64'hBEEF, 0, 1);
    cyc(0, 6'd0, 4'd0, 64'h0, 0, 1);
    chk("t5_nowb", popq.size(), 0);
    // randomized traffic
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? 6'd0 : 6'($urandom_range(1, 63)),
          4'($urandom), {$urandom, $urandom}, $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1);
    // asynchronous reset between edges mid-burst
    for (int k = 0; k < 4; k++) cyc(1, 6'(k + 1), 4'(k), 64'(k + 1), 0, 0);
    nrst = 1'b0;
    iv = 1'b0;
    #2 chk_reset_outs("arst");
    q.delete();
    m_inf = 1'b0;
    @(negedge clk) nrst = 1'b1;
    @(posedge clk) #1;
    popq.delete();
    for (int k = 0; k < 4; k++) cyc(0, 6'd0, 4'd0, 64'h0, 0, 1);
    chk("t6_nowb", popq.size(), 0);
    for (int k = 0; k < 100; k++)
      cyc($urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)), 4'($urandom),
          {$urandom, $urandom}, 1'b0, $urandom_range(0, 3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
